// File: rtl/jtkicker_objslot_pkg.sv
// jtkicker_objslot_pkg
// Shared constants and types for the kicker object-ROM slot.
//   SDRAM_AW : SDRAM word address width (16-bit words)
//   WORDS    : 16-bit words fetched per miss (2, or 4 with JTKICKER_OBJSLOT_PAIR_EN)
//   WCNT_W   : width of the fill word counter
//   state_e  : fetch state encoding (IDLE / REQ / WAIT)
// Optional feature macro: JTKICKER_OBJSLOT_PAIR_EN (even/odd pair cache).
package jtkicker_objslot_pkg;

  localparam int SDRAM_AW = 22;

`ifdef JTKICKER_OBJSLOT_PAIR_EN
  localparam int WORDS = 4;
`else
  localparam int WORDS = 2;
`endif

  localparam int WCNT_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/jtkicker_objslot.sv
// jtkicker_objslot
// Responder for the object engine ROM port. A 32-bit request that misses the
// one-entry tagged cache becomes an SDRAM read of consecutive 16-bit words;
// the words are assembled and the entry is tagged valid. Repeat reads of the
// cached address complete combinationally with no SDRAM traffic.
//
// Ports
//   rst, clk                 asynchronous active-high reset, system clock
//   rom_cs, rom_addr         client request (held until rom_ok)
//   rom_ok, rom_data         hit indication and cached 32-bit word
//   inv                      invalidate the cache
//   sdram_req, sdram_addr    SDRAM read request (held until sdram_ack)
//   sdram_ack                request accepted
//   sdram_dok, sdram_data    one 16-bit read word per strobe
//
// Optional feature macro: JTKICKER_OBJSLOT_PAIR_EN
//   Defined: the entry holds an even/odd 32-bit pair fetched as 4 words, the
//   tag ignores rom_addr[0] and rom_data is selected by rom_addr[0].
module jtkicker_objslot
  import jtkicker_objslot_pkg::*;
#(
  parameter int                  AW     = 13,
  parameter logic [SDRAM_AW-1:0] OFFSET = 22'h0
) (
  input  logic                rst,
  input  logic                clk,
  input  logic                rom_cs,
  input  logic [AW-1:0]       rom_addr,
  output logic                rom_ok,
  output logic [31:0]         rom_data,
  input  logic                inv,
  output logic                sdram_req,
  output logic [SDRAM_AW-1:0] sdram_addr,
  input  logic                sdram_ack,
  input  logic                sdram_dok,
  input  logic [15:0]         sdram_data
);

`ifdef JTKICKER_OBJSLOT_PAIR_EN
  localparam int TAG_W = AW - 1;
`else
  localparam int TAG_W = AW;
`endif

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS - 1);

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  // Tag of the fetch in flight; only the tag bits of the request are needed.
  logic [TAG_W-1:0]    req_tag_q, req_tag_d;
  logic                valid_q, valid_d;
  // Remembers an invalidate seen while a fetch was in flight.
  logic                inv_pend_q, inv_pend_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                sdram_req_q, sdram_req_d;
  logic [SDRAM_AW-1:0] sdram_addr_q, sdram_addr_d;
  logic [15:0]         words_q [WORDS];
  logic [15:0]         words_d [WORDS];

  logic [TAG_W-1:0]    rom_tag;
  logic [SDRAM_AW-1:0] fetch_addr;
  logic                hit;

`ifdef JTKICKER_OBJSLOT_PAIR_EN
  assign rom_tag    = rom_addr[AW-1:1];
  assign fetch_addr = OFFSET + {{(SDRAM_AW-AW-1){1'b0}}, rom_addr[AW-1:1], 2'b00};
  assign rom_data   = rom_addr[0] ? {words_q[3], words_q[2]} : {words_q[1], words_q[0]};
`else
  assign rom_tag    = rom_addr;
  assign fetch_addr = OFFSET + {{(SDRAM_AW-AW-1){1'b0}}, rom_addr, 1'b0};
  assign rom_data   = {words_q[1], words_q[0]};
`endif

  assign hit        = valid_q && (tag_q == rom_tag);
  // Gating on IDLE keeps a half-written word set from ever being reported.
  assign rom_ok     = rom_cs && hit && (state_q == ST_IDLE);
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tag_q        <= '0;
      req_tag_q    <= '0;
      valid_q      <= 1'b0;
      inv_pend_q   <= 1'b0;
      wcnt_q       <= '0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      for (int i = 0; i < WORDS; i++) words_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      req_tag_q    <= req_tag_d;
      valid_q      <= valid_d;
      inv_pend_q   <= inv_pend_d;
      wcnt_q       <= wcnt_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      for (int i = 0; i < WORDS; i++) words_q[i] <= words_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rom_cs && !hit && !inv) state_d = ST_REQ;
      ST_REQ:  if (sdram_ack) state_d = ST_WAIT;
      ST_WAIT: if (sdram_dok && wcnt_q == WCNT_LAST) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tag_d        = tag_q;
    req_tag_d    = req_tag_q;
    valid_d      = valid_q;
    inv_pend_d   = inv_pend_q;
    wcnt_d       = wcnt_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    words_d      = words_q;

    if (inv) begin
      valid_d = 1'b0;
      if (state_q != ST_IDLE) inv_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (rom_cs && !hit && !inv) begin
          req_tag_d    = rom_tag;
          sdram_addr_d = fetch_addr;
          sdram_req_d  = 1'b1;
          wcnt_d       = '0;
          inv_pend_d   = 1'b0;
        end
      end
      ST_REQ: begin
        if (sdram_ack) sdram_req_d = 1'b0;
      end
      ST_WAIT: begin
        if (sdram_dok) begin
          words_d[wcnt_q] = sdram_data;
          wcnt_d          = wcnt_q + WCNT_W'(1);
          if (wcnt_q == WCNT_LAST) begin
            tag_d      = req_tag_q;
            // An invalidate at any time during the fetch, including this
            // cycle, leaves the freshly filled entry unusable.
            valid_d    = !(inv || inv_pend_q);
            inv_pend_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/jtkicker_objslot.md
# jtkicker_objslot

Responder side of the object engine's ROM request interface (`rom_cs` / `rom_addr` / `rom_ok` / `rom_data`). It turns each 32-bit sprite-row request into an SDRAM read of consecutive 16-bit words, assembles the words, and holds the result in a small tagged cache. Re-reads of the same address complete without SDRAM traffic. The block sits between the kicker object renderer and one SDRAM arbiter slot.

## Interface
- `AW`, 13, client word address width (32-bit words)
- `OFFSET`, 22'h0, SDRAM base address in 16-bit words
- `rst`  in  1  asynchronous reset, active-high
- `clk`  in  1  system clock, 48 MHz
- `rom_cs`  in  1  client request, held until `rom_ok`
- `rom_addr`  in  AW  client word address
- `rom_ok`  out  1  `rom_data` valid for the current `rom_addr`
- `rom_data`  out  32  fetched word
- `inv`  in  1  invalidate cache (ROM download / bank change)
- `sdram_req`  out  1  read request, held until `sdram_ack`
- `sdram_addr`  out  22  SDRAM word address
- `sdram_ack`  in  1  request accepted
- `sdram_dok`  in  1  one 16-bit data word valid
- `sdram_data`  in  16  SDRAM read data

## Operation
- Registered state: `tag[AW-1:0]`, `valid`, `req_addr`, data words, word counter `wcnt`. States are IDLE, REQ and WAIT.
- **Hit rule.** `rom_ok` = `rom_cs & valid & (state==IDLE) & (tag==rom_addr)`. This is combinational on registered state, so `rom_ok` drops in the same cycle that `rom_addr` changes to a non-matching value.
- **IDLE.**
  - On `rom_cs`, miss and `!inv`: latch `req_addr` = `rom_addr`, `sdram_addr` = `OFFSET + {rom_addr,1'b0}` (22-bit, modulo 2^22), set `sdram_req`=1, `wcnt`=0, go to REQ.
  - While `rom_cs` is low, the block stays idle.
- **REQ.**
  - On `sdram_ack`: `sdram_req`=0, go to WAIT.
  - `sdram_dok` in REQ is ignored.
- **WAIT.**
  - Each `sdram_dok` stores `sdram_data` into word `wcnt` (word 0 → `rom_data[15:0]`, word 1 → `[31:16]`) and increments `wcnt`.
  - On the last word: `tag`=`req_addr`, `valid`=1, go to IDLE.
- **Uncancellable fetch.** Once requested, a fetch always runs to completion; dropping `rom_cs` or changing `rom_addr` mid-fetch does not abort it.
  - On return to IDLE, the hit rule is re-evaluated.
  - A changed address produces a fresh miss.
- **Invalidate.** `inv` clears `valid` immediately.
  - If `inv` is asserted at any point during a fetch, that fetch still completes on the SDRAM side but leaves `valid`=0.
  - `inv` has priority over a simultaneous fill.
- `sdram_ack` outside REQ and `sdram_dok` outside WAIT are ignored.
- `rom_data` changes only on fills; it holds its value otherwise.

## Timing
- **Reset values.** `rom_ok`=0, `rom_data`=0, `sdram_req`=0, `sdram_addr`=0, `valid`=0, `tag`=0, state IDLE.
- **Hit latency.** 0 cycles: `rom_ok` rises in the cycle `rom_cs` is high with a matching tag.
- **Miss latency.**
  - Miss seen at cycle N; `sdram_req` is high from N+1.
  - Acknowledge at cycle A ≥ N+1; `sdram_req` is low from A+1.
  - Last `dok` at cycle M > A; `rom_ok` is high from M+1.
- A request overlaps no other request: at most one outstanding SDRAM read.
- An address change in the same cycle as the fill completes: the tag holds the old `req_addr`, and the miss is detected at M+1, issuing a request at M+2.

## Configuration
- **`JTKICKER_OBJSLOT_PAIR_EN` defined.**
  - Cache holds an even/odd pair. A miss on either address fetches both: `sdram_addr` = `OFFSET + {rom_addr[AW-1:1],2'b00}`, 4 `dok` words.
  - Words 0–1 form the even entry and words 2–3 the odd entry. `tag` is stored without bit 0, and the hit compares `rom_addr[AW-1:1]`.
  - The renderer's second-half read (`rom_addr[0]`=1) then hits in 0 cycles.
  - The output mux selects on `rom_addr[0]`.
- **Undefined.** Single 32-bit entry with a 2-word fetch, as described above.

## Structure
- Package `jtkicker_objslot_pkg` holds:
  - the state encoding (IDLE, REQ, WAIT);
  - the `WORDS` constant (2, or 4 with the macro);
  - the 22-bit SDRAM address width constant.
- Single module; no sub-module. Word assembly is a small register file indexed by `wcnt`.

## Test plan
- **Reset, then simple miss.** Drive `rom_cs`=1, `rom_addr`=13'h0010. Check `sdram_req` at N+1 with `sdram_addr`=22'h000020. Ack after 3 cycles, then `dok` words 16'h1234 and 16'hABCD. Check `rom_ok`=1 with `rom_data`=32'hABCD1234 one cycle after the last `dok`.
- **Hit.** Drop `rom_cs`, then re-request 13'h0010. Check `rom_ok` is high in the same cycle and `sdram_req` never rises.
- **Address change mid-fetch.** Request 13'h0020; after the ack, switch to 13'h0021. Check that the first fetch completes, `rom_ok` stays low, and a new request for 22'h000042 issues two cycles after the fill.
- **`inv` during WAIT.** Check that the fill completes, `valid`=0, and the same address re-requests.
- **PAIR_EN.** Request 13'h0031. Check `sdram_addr`=22'h000060 and a 4-word burst 1,2,3,4. Check `rom_data`=32'h00040003, then address 13'h0030 hits at once with 32'h00020001.
- **Reset mid-WAIT, and stray strobes.** Assert `rst` during WAIT: check all outputs return to reset values and subsequent stray `dok` strobes are ignored.
